// File: rtl/ser_link.sv
// ser_link: serial transmitter with abortable frames looped into a receiver that reassembles and compares each word
module ser_link #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             abort,
    output logic             busy,
    output logic             ser_data,
    output logic             ser_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             match,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] TX_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] RX_LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [WIDTH-1:0] tx_word, tx_sh, rx_sh, rx_nxt;
    logic done;
    assign done = tx_cnt == TX_LAST;
    assign busy = state != IDLE;
    assign rx_nxt = MSB_FIRST ? {rx_sh[WIDTH-2:0], ser_data} : {ser_data, rx_sh[WIDTH-1:1]};
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE  ? (load ? SHIFT : IDLE) :
                    state == SHIFT ? ((done || abort) ? GAP : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_word  <= '0;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            ser_vld  <= 1'b0;
            ser_data <= 1'b0;
        end else if (state == IDLE && load) begin
            tx_word  <= din;
            tx_cnt   <= CW'(1);
            ser_vld  <= 1'b1;
            ser_data <= MSB_FIRST ? din[WIDTH-1] : din[0];
            tx_sh    <= MSB_FIRST ? din << 1 : din >> 1;
        end else if (state == SHIFT) begin
            if (done || abort) begin
                tx_cnt   <= '0;
                ser_vld  <= 1'b0;
                ser_data <= 1'b0;
            end else begin
                tx_cnt   <= tx_cnt + CW'(1);
                ser_data <= MSB_FIRST ? tx_sh[WIDTH-1] : tx_sh[0];
                tx_sh    <= MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
            end
        end
    end
    // the WIDTH-th bit is folded in combinationally so dout lands on the edge that accepts it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_sh     <= '0;
            rx_cnt    <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            match     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (ser_vld) begin
                rx_sh <= rx_nxt;
                if (rx_cnt == RX_LAST) begin
                    rx_cnt   <= '0;
                    dout     <= rx_nxt;
                    dout_vld <= 1'b1;
                    match    <= rx_nxt == tx_word;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end else if (rx_cnt != '0) begin
                rx_cnt    <= '0;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ser_link.sv
// tb_ser_link: drives LSB-first and MSB-first instances with one stimulus stream against a frame-level model
module tb_ser_link;
    localparam int W = 8;
    logic clk = 1'b0, n_rst = 1'b0, load = 1'b0, abort = 1'b0;
    logic [W-1:0] din = '0;
    logic busy[2], ser_data[2], ser_vld[2], dout_vld[2], match[2], frame_err[2];
    logic [W-1:0] dout[2];
    int checks = 0, errors = 0;
    logic [W-1:0] m_word, m_dout;
    logic m_match, m_dv, m_fe, m_fr;
    int m_t, m_nb;
    ser_link #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .n_rst(n_rst), .din(din), .load(load), .abort(abort),
        .busy(busy[0]), .ser_data(ser_data[0]), .ser_vld(ser_vld[0]), .dout(dout[0]),
        .dout_vld(dout_vld[0]), .match(match[0]), .frame_err(frame_err[0])
    );
    ser_link #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .n_rst(n_rst), .din(din), .load(load), .abort(abort),
        .busy(busy[1]), .ser_data(ser_data[1]), .ser_vld(ser_vld[1]), .dout(dout[1]),
        .dout_vld(dout_vld[1]), .match(match[1]), .frame_err(frame_err[1])
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_fr = 1'b0; m_t = 0; m_nb = 0; m_dout = '0; m_match = 1'b0; m_dv = 1'b0; m_fe = 1'b0;
    endtask
    // m_t counts edges since the accepting edge, m_nb is the number of bits the frame actually sends
    task automatic model_edge();
        m_dv = 1'b0;
        m_fe = 1'b0;
        if (m_fr && m_t <= m_nb) begin
            m_t++;
            if (abort && m_t < W && m_nb == W) m_nb = m_t;
            if (m_t == W && m_nb == W) begin
                m_dout = m_word; m_dv = 1'b1; m_match = 1'b1;
            end
            if (m_t == m_nb + 1 && m_nb < W) m_fe = 1'b1;
        end else if (load) begin
            m_word = din; m_t = 0; m_nb = W; m_fr = 1'b1;
        end
    endtask
    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            logic ev, ed;
            ev = m_fr && m_t < m_nb;
            ed = ev && (i == 1 ? m_word[W-1-m_t] : m_word[m_t]);
            chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_fr && m_t <= m_nb));
            chk($sformatf("ser_vld%0d", i), 32'(ser_vld[i]), 32'(ev));
            chk($sformatf("ser_data%0d", i), 32'(ser_data[i]), 32'(ed));
            chk($sformatf("dout%0d", i), 32'(dout[i]), 32'(m_dout));
            chk($sformatf("dout_vld%0d", i), 32'(dout_vld[i]), 32'(m_dv));
            chk($sformatf("match%0d", i), 32'(match[i]), 32'(m_match));
            chk($sformatf("frame_err%0d", i), 32'(frame_err[i]), 32'(m_fe));
        end
    endtask
    task automatic cyc(input logic ld, input logic ab, input logic [W-1:0] d);
        load = ld; abort = ab; din = d;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask
    task automatic do_reset();
        #2 n_rst = 1'b0;
        #1 model_reset();
        compare();
        @(posedge clk);
        #1 compare();
        n_rst = 1'b1;
    endtask
    initial begin
        model_reset();
        @(posedge clk);
        #1 compare();
        n_rst = 1'b1;
        cyc(1, 0, 8'h01);
        repeat (11) cyc(0, 0, 8'h00);
        chk("dout_01", 32'(dout[0]), 32'h01);
        cyc(1, 0, 8'hA5);
        repeat (18) cyc(1, 0, 8'h3C);
        repeat (12) cyc(0, 0, 8'h00);
        chk("dout_3c", 32'(dout[1]), 32'h3C);
        cyc(1, 0, 8'hFF);
        repeat (2) cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        repeat (6) cyc(0, 1, 8'h00);
        chk("dout_kept", 32'(dout[0]), 32'h3C);
        cyc(1, 0, 8'hC3);
        repeat (4) cyc(0, 0, 8'h00);
        do_reset();
        cyc(1, 0, 8'h5A);
        repeat (11) cyc(0, 0, 8'h00);
        chk("dout_5a", 32'(dout[1]), 32'h5A);
        cyc(1, 1, 8'h96);
        repeat (7) cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h00);
        repeat (4) cyc(0, 0, 8'h00);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, W'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
